// File: rtl/spi_word_receiver_pkg.sv
// Shared SPI receiver types: mode encodings, frame states and sample-edge helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } frame_state_e;

  // Mode is {CPOL,CPHA}; equal bits mean data is sampled on the rising spi_clk edge.
  function automatic logic sample_rising(input logic [1:0] mode);
    return ~(mode[1] ^ mode[0]);
  endfunction

endpackage

// File: rtl/spi_word_receiver_if.sv
// Received-word stream: producer drives data/valid, consumer drives ready.
interface spi_word_receiver_if #(parameter int WORD_WIDTH = 32) ();
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/spi_word_receiver_fifo.sv
// Word buffer: count-tracked circular RAM, first-word-fall-through read port.
module spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_rd, w_wr;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign rd_data = r_mem[r_rptr];
  assign w_rd    = rd_en & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still takes the write.
  assign w_wr    = wr_en & (~full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end
endmodule

// File: rtl/spi_word_receiver.sv
// SPI slave receiver: synchronises the SPI pins into clk, assembles MSB-first words, buffers them.
module spi_word_receiver
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SPI_MODE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  input  logic clear_flags,
  output logic overflow,
  output logic frame_error,
  spi_word_receiver_if.master out_if
);
  localparam logic [1:0] MODE        = SPI_MODE[1:0];
  localparam logic       CPOL        = MODE[1];
  localparam logic       SAMPLE_RISE = sample_rising(MODE);
  localparam int         CW          = $clog2(WORD_WIDTH + 1);

  logic [2:0]            r_sclk;
  logic [1:0]            r_mosi, r_cs, r_fill;
  logic                  r_armed;
  frame_state_e          r_state;
  logic [CW-1:0]         r_bits;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_overflow, r_frame_error;

  logic                  w_cs, w_edge, w_active, w_word, w_flush_err;
  logic                  w_full, w_empty, w_pop, w_drop;
  logic [WORD_WIDTH-1:0] w_rd_data;

  assign w_cs        = r_cs[1];
  assign w_edge      = SAMPLE_RISE ? (r_sclk[1] & ~r_sclk[2]) : (~r_sclk[1] & r_sclk[2]);
  // Shifting may start in the same cycle the FSM leaves IDLE, so no first-bit edge is lost.
  assign w_active    = ~w_cs & ((r_state == ST_SHIFT) | ((r_state == ST_IDLE) & r_armed));
  assign w_word      = (r_bits == CW'(WORD_WIDTH));
  assign w_flush_err = (r_state == ST_FLUSH) & (r_bits != '0) & ~w_word;
  assign w_pop       = ~w_empty & out_if.out_ready;
  assign w_drop      = w_word & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk        <= {3{CPOL}};
      r_mosi        <= '0;
      r_cs          <= 2'b11;
      r_fill        <= '0;
      r_armed       <= 1'b0;
      r_state       <= ST_IDLE;
      r_bits        <= '0;
      r_shift       <= '0;
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sclk <= {r_sclk[1:0], spi_clk};
      r_mosi <= {r_mosi[0], spi_mosi};
      r_cs   <= {r_cs[0], spi_cs_n};
      r_fill <= {r_fill[0], 1'b1};
      // Only a cs_n seen high after the synchroniser holds real samples arms a new frame,
      // so a frame cut by reset is ignored until cs_n has risen and fallen again.
      if (r_fill[1] & w_cs) r_armed <= 1'b1;

      case (r_state)
        ST_IDLE:  if (~w_cs & r_armed) r_state <= ST_SHIFT;
        ST_SHIFT: if (w_cs) r_state <= ST_FLUSH;
        default:  r_state <= ST_IDLE;
      endcase

      if (w_edge & w_active) begin
        r_shift <= {r_shift[WORD_WIDTH-2:0], r_mosi[1]};
        r_bits  <= w_word ? CW'(1) : r_bits + CW'(1);
      end else if (w_word | w_flush_err) begin
        r_bits <= '0;
      end

      r_overflow    <= w_drop      | (r_overflow    & ~clear_flags);
      r_frame_error <= w_flush_err | (r_frame_error & ~clear_flags);
    end
  end

  spi_rx_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (w_word),
    .wr_data (r_shift),
    .full    (w_full),
    .rd_en   (out_if.out_ready),
    .rd_data (w_rd_data),
    .empty   (w_empty)
  );

  assign out_if.out_valid = ~w_empty;
  assign out_if.out_data  = w_empty ? '0 : w_rd_data;
  assign overflow         = r_overflow;
  assign frame_error      = r_frame_error;
endmodule
